mx_block_encoder: RTL and testbench

- Streaming MX quantiser; the producer side of the MX element format that the dot-product units consume.
- Accepts signed fixed-point values one per cycle and buffers a block of k values.
- Derives one shared power-of-two scale from the block maximum.
- Encodes each value into a (1 + exp_width + man_width)-bit element and presents the whole block as a parallel vector plus scale. The output port matches the i_vec_a / i_vec_b inputs of the dot units.

---
 rtl/mx_block_encoder.sv | 197 +++++++++++++++++++
 tb/tb_mx_block_encoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mx_block_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mx_block_encoder                                              |
// | Purpose  : Streaming MX quantiser. Buffers K signed samples, derives one |
// |            shared power-of-two scale from the block max |x| and encodes |
// |            each sample as a {sign, exp, man} element.                    |
// | Options  : define MX_ENC_RNE_EN for round-to-nearest-even with          |
// |            saturation; default build truncates toward zero.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mx_block_encoder #(
  parameter int EXP_WIDTH   = 4,
  parameter int MAN_WIDTH   = 3,
  parameter int K           = 32,
  parameter int IN_WIDTH    = 24,
  parameter int SCALE_WIDTH = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [IN_WIDTH-1:0]                           i_data,
  input  logic                                          i_valid,
  output logic                                          o_ready_in,
  output logic [K-1:0][EXP_WIDTH+MAN_WIDTH:0]           o_vec,
  output logic [SCALE_WIDTH-1:0]                        o_scale,
  output logic                                          o_valid,
  input  logic                                          i_ready
);

  localparam int EW = 1 + EXP_WIDTH + MAN_WIDTH;
  // Bit position of the largest element magnitude (exp all ones, man all ones)
  localparam int T  = MAN_WIDTH + (1 << EXP_WIDTH) - 2;
  localparam int CW = $clog2(K);

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_SCALE  = 2'd1;
  localparam logic [1:0] ST_ENCODE = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [IN_WIDTH-1:0]    maxabs_q, maxabs_d;
  logic [SCALE_WIDTH-1:0] scale_q, scale_d;
  logic                   valid_q, valid_d;
  logic [K-1:0][EW-1:0]   vec_q;
  logic [IN_WIDTH-1:0]    buf_q [K];

  logic                   w_accept;
  logic [IN_WIDTH-1:0]    w_in_mag;
  int                     w_p;
  logic [SCALE_WIDTH-1:0] w_scale;
  logic [EW-1:0]          w_elem;

  // Index of the highest set bit (0 when the value is zero)
  function automatic int msb_idx(input logic [IN_WIDTH:0] v);
    int r;
    r = 0;
    for (int i = 0; i <= IN_WIDTH; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  // Encode one sample against the shared scale s
  function automatic logic [EW-1:0] encode_elem(input logic [IN_WIDTH-1:0] x,
                                                input logic [SCALE_WIDTH-1:0] s);
    logic [IN_WIDTH-1:0] mag;
    logic [IN_WIDTH:0]   m;     // extra bit absorbs a rounding carry
    logic [IN_WIDTH:0]   kept;
    logic [EW-1:0]       enc;
    int                  q;
    int                  e;
    int                  sh;
`ifdef MX_ENC_RNE_EN
    logic [IN_WIDTH:0]   one;
    logic [IN_WIDTH:0]   rem;
    logic [IN_WIDTH:0]   half;
    one = (IN_WIDTH+1)'(1);
`endif
    mag = x[IN_WIDTH-1] ? (~x + 1'b1) : x;
    m   = {1'b0, mag} >> s;
`ifdef MX_ENC_RNE_EN
    if (s != '0) begin
      rem  = {1'b0, mag} & ((one << s) - one);
      half = one << (s - 1'b1);
      if (rem > half || (rem == half && m[0])) m = m + one;
    end
`endif
    enc = '0;
    if (m != '0) begin
      q = msb_idx(m);
      if (q < MAN_WIDTH) begin
        e    = 0;
        kept = m;
      end else begin
        sh   = q - MAN_WIDTH;
        kept = m >> sh;
        e    = q - MAN_WIDTH + 1;
`ifdef MX_ENC_RNE_EN
        if (sh > 0) begin
          rem  = m & ((one << sh) - one);
          half = one << (sh - 1);
          if (rem > half || (rem == half && kept[0])) kept = kept + one;
          // Rounding up a mantissa of all ones bumps the exponent
          if (kept[MAN_WIDTH+1]) begin
            kept = kept >> 1;
            e    = e + 1;
          end
        end
        if (e > (1 << EXP_WIDTH) - 1) begin
          e    = (1 << EXP_WIDTH) - 1;
          kept = '1;
        end
`endif
      end
      enc = {x[IN_WIDTH-1], EXP_WIDTH'(e), MAN_WIDTH'(kept)};
    end
    return enc;
  endfunction

  assign o_ready_in = (state_q == ST_FILL) && !rst;
  assign w_accept   = i_valid && o_ready_in;
  assign w_in_mag   = i_data[IN_WIDTH-1] ? (~i_data + 1'b1) : i_data;
  assign w_p        = msb_idx({1'b0, maxabs_q});
  assign w_scale    = (maxabs_q == '0 || w_p <= T) ? '0 : SCALE_WIDTH'(w_p - T);
  assign w_elem     = encode_elem(buf_q[count_q], scale_q);

  assign o_vec   = vec_q;
  assign o_scale = scale_q;
  assign o_valid = valid_q;

  // Next-state logic: fill, scale, encode one element per cycle, hold output
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    maxabs_d = maxabs_q;
    scale_d  = scale_q;
    valid_d  = valid_q;
    case (state_q)
      ST_FILL: begin
        if (w_accept) begin
          count_d = count_q + 1'b1;
          if (w_in_mag > maxabs_q) maxabs_d = w_in_mag;
          if (count_q == CW'(K - 1)) begin
            count_d = '0;
            state_d = ST_SCALE;
          end
        end
      end
      ST_SCALE: begin
        scale_d = w_scale;
        state_d = ST_ENCODE;
      end
      ST_ENCODE: begin
        count_d = count_q + 1'b1;
        if (count_q == CW'(K - 1)) begin
          count_d = '0;
          valid_d = 1'b1;
          state_d = ST_OUT;
        end
      end
      default: begin
        if (i_ready) begin
          valid_d  = 1'b0;
          maxabs_d = '0;
          count_d  = '0;
          state_d  = ST_FILL;
        end
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FILL;
      count_q  <= '0;
      maxabs_q <= '0;
      scale_q  <= '0;
      valid_q  <= 1'b0;
      vec_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      maxabs_q <= maxabs_d;
      scale_q  <= scale_d;
      valid_q  <= valid_d;
      if (state_q == ST_ENCODE) vec_q[count_q] <= w_elem;
    end
  end

  // Sample buffer; contents are meaningless until count says otherwise
  always_ff @(posedge clk) begin
    if (w_accept) buf_q[count_q] <= i_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_mx_block_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mx_block_encoder                                           |
// | Purpose  : Directed + random scoreboard bench for mx_block_encoder.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mx_block_encoder;

  localparam int K = 32;

  typedef struct {
    logic [K-1:0][7:0] vec;
    logic [7:0]        scale;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [23:0]       i_data;
  logic              i_valid;
  logic              o_ready_in;
  logic [K-1:0][7:0] o_vec;
  logic [7:0]        o_scale;
  logic              o_valid;
  logic              i_ready;

  int          errors;
  int          checks;
  logic [23:0] blk [K];
  exp_t        q_exp[$];
  exp_t        cur;
  exp_t        ones_exp;

  mx_block_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready_in (o_ready_in),
    .o_vec      (o_vec),
    .o_scale    (o_scale),
    .o_valid    (o_valid),
    .i_ready    (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Round-to-nearest-even of val / 2^sh
  function automatic longint rnd(input longint val, input int sh);
    longint q, r, h;
    if (sh == 0) return val;
    q = val >> sh;
    r = val - (q << sh);
    h = longint'(1) << (sh - 1);
    if (r > h || (r == h && (q & 1) == 1)) q = q + 1;
    return q;
  endfunction

  // Reference element encoder: normalise by repeated halving
  function automatic logic [7:0] m_enc(input logic [23:0] x, input int s);
    longint mag, m, v;
    int     e, sh;
    mag = x[23] ? (longint'(1) << 24) - longint'(x) : longint'(x);
`ifdef MX_ENC_RNE_EN
    m = rnd(mag, s);
`else
    m = mag >> s;
`endif
    if (m == 0) return 8'h00;
    if (m < 8) begin
      e = 0;
      v = m;
    end else begin
      sh = 0;
      while ((m >> sh) >= 16) sh++;
`ifdef MX_ENC_RNE_EN
      v = rnd(m, sh);
`else
      v = m >> sh;
`endif
      e = sh + 1;
      if (v == 16) begin
        v = 8;
        e = e + 1;
      end
      if (e > 15) begin
        e = 15;
        v = 15;
      end
    end
    return {x[23], 4'(e), 3'(v)};
  endfunction

  function automatic exp_t model_block();
    exp_t   r;
    longint mx, mag;
    int     p, s;
    mx = 0;
    for (int i = 0; i < K; i++) begin
      mag = blk[i][23] ? (longint'(1) << 24) - longint'(blk[i]) : longint'(blk[i]);
      if (mag > mx) mx = mag;
    end
    p = 0;
    for (int b = 0; b < 25; b++) if (((mx >> b) & 1) == 1) p = b;
    s = (mx != 0 && p > 17) ? p - 17 : 0;
    for (int i = 0; i < K; i++) r.vec[i] = m_enc(blk[i], s);
    r.scale = 8'(s);
    return r;
  endfunction

  // Offer one sample and hold it until the encoder takes it
  task automatic send(input logic [23:0] x);
    int n;
    n = 0;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = x;
    while (!o_ready_in && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", o_ready_in, 1);
    @(posedge clk);
  endtask

  task automatic send_block();
    q_exp.push_back(model_block());
    for (int i = 0; i < K; i++) send(blk[i]);
  endtask

  // Wait for a block, pop its expectation and compare
  task automatic wait_out(input string tag, input bit chk_lat);
    int cnt;
    cnt = 0;
    @(negedge clk);
    i_valid = 1'b0;
    while (!o_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_valid"}, o_valid, 1);
    if (chk_lat) chk({tag, "_latency"}, cnt, K + 1);
    if (q_exp.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
    end else begin
      cur = q_exp.pop_front();
      chk({tag, "_scale"}, o_scale, cur.scale);
      chk({tag, "_vec"}, o_vec, cur.vec);
    end
  endtask

  task automatic finish_blk(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid_drop"}, o_valid, 0);
    chk({tag, "_ready_back"}, o_ready_in, 1);
  endtask

  task automatic ones_block();
    for (int i = 0; i < K; i++) blk[i] = 24'd1;
  endtask

  initial begin
    logic signed [23:0] tmp;
    int                 sh, r;
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;
    for (int i = 0; i < K; i++) ones_exp.vec[i] = 8'h01;
    ones_exp.scale = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready_in, 0);
    chk("rst_vec", o_vec, 0);
    chk("rst_scale", o_scale, 0);
    rst = 1'b0;
    #1;
    chk("rst_ready_after", o_ready_in, 1);

    // All +1 with latency check
    ones_block();
    send_block();
    wait_out("ones", 1'b1);
    chk("ones_const", o_vec, ones_exp.vec);
    finish_blk("ones");

    // Single 120
    for (int i = 0; i < K; i++) blk[i] = 24'd0;
    blk[0] = 24'd120;
    send_block();
    wait_out("s120", 1'b1);
    chk("s120_e0", o_vec[0], 8'h27);
    chk("s120_e1", o_vec[1], 8'h00);
    finish_blk("s120");

    // Full-scale negative plus small values
    blk[0] = 24'h800000;
    blk[1] = 24'd100;
    blk[2] = 24'd127;
    blk[3] = -24'sd63;
    send_block();
    wait_out("big", 1'b0);
    chk("big_scale_const", o_scale, 8'd6);
    chk("big_e0", o_vec[0], 8'hF8);
`ifdef MX_ENC_RNE_EN
    chk("big_e2", o_vec[2], 8'h02);
    chk("big_e3", o_vec[3], 8'h81);
`else
    chk("big_e1", o_vec[1], 8'h01);
    chk("big_e2", o_vec[2], 8'h01);
    chk("big_e3", o_vec[3], 8'h00);
`endif
    finish_blk("big");

    // Backpressure: hold output, offer samples that must be ignored
    ones_block();
    i_ready = 1'b0;
    send_block();
    wait_out("bp", 1'b0);
    i_valid = 1'b1;
    i_data  = 24'h3FF000;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid_hold", o_valid, 1);
      chk("bp_ready_low", o_ready_in, 0);
      chk("bp_vec_hold", o_vec, cur.vec);
      chk("bp_scale_hold", o_scale, cur.scale);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    finish_blk("bp");
    send_block();
    wait_out("bp_next", 1'b0);
    chk("bp_next_const", o_vec, ones_exp.vec);
    finish_blk("bp_next");

    // Reset in the middle of a fill
    for (int i = 0; i < 10; i++) send(24'h400000);
    @(negedge clk);
    i_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_ready", o_ready_in, 0);
    chk("mrst_valid", o_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_block();
    wait_out("mrst", 1'b1);
    chk("mrst_scale_const", o_scale, 8'd0);
    chk("mrst_vec_const", o_vec, ones_exp.vec);
    finish_blk("mrst");

    // Random back-to-back blocks
    for (int b = 0; b < 300; b++) begin
      sh = $urandom_range(0, 23);
      for (int i = 0; i < K; i++) begin
        r = $urandom_range(0, 63);
        tmp = 24'($urandom);
        if (r == 0)      blk[i] = 24'd0;
        else if (r == 1) blk[i] = 24'h800000;
        else             blk[i] = tmp >>> sh;
      end
      send_block();
      wait_out("rnd", 1'b0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
